// File: rtl/fifo_mem_mc.sv
// fifo_mem_mc: NUM_CH independent circular queues sharing one write port and one read port,
// with per-channel occupancy, watermark flags and sticky error flags.
module fifo_mem_mc #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_CH     = 4,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH + 1),
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    input  logic [CH_W-1:0]         rd_ch,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_valid,
    output logic [NUM_CH-1:0]       full,
    output logic [NUM_CH-1:0]       empty,
    output logic [NUM_CH-1:0]       almost_full,
    output logic [NUM_CH-1:0]       almost_empty,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       wr_full_err,
    output logic [NUM_CH-1:0]       rd_empty_err,
    input  logic                    err_clr
);
    logic [WIDTH-1:0] mem [NUM_CH][DEPTH];
    logic [PTR_W-1:0] wr_ptr [NUM_CH];
    logic [PTR_W-1:0] rd_ptr [NUM_CH];
    logic [CNT_W-1:0] cnt [NUM_CH];
    logic wr_v, rd_v, wr_acc, rd_acc;
    logic [NUM_CH-1:0] wr_sel, rd_sel, inc, dec, wr_err, rd_err;

    // Out-of-range channel indices never select anything.
    assign wr_v   = wr_en && ({1'b0, wr_ch} < (CH_W + 1)'(NUM_CH));
    assign rd_v   = rd_en && ({1'b0, rd_ch} < (CH_W + 1)'(NUM_CH));
    assign wr_acc = |inc;
    assign rd_acc = |dec;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign full[g]         = cnt[g] == CNT_W'(DEPTH);
        assign empty[g]        = cnt[g] == '0;
        assign almost_full[g]  = cnt[g] >= CNT_W'(AFULL_LVL);
        assign almost_empty[g] = cnt[g] <= CNT_W'(AEMPTY_LVL);
        assign count[g*CNT_W +: CNT_W] = cnt[g];
        assign wr_sel[g] = wr_v && (wr_ch == CH_W'(g));
        assign rd_sel[g] = rd_v && (rd_ch == CH_W'(g));
        assign dec[g]    = rd_sel[g] && !empty[g];
        // A full channel still takes a write when the same cycle pops its head.
        assign inc[g]    = wr_sel[g] && (!full[g] || dec[g]);
        assign wr_err[g] = wr_sel[g] && !inc[g];
        assign rd_err[g] = rd_sel[g] && empty[g];

        always_ff @(posedge CLK) begin
            if (RST) begin
                wr_ptr[g] <= '0;
                rd_ptr[g] <= '0;
                cnt[g]    <= '0;
            end else begin
                if (inc[g]) wr_ptr[g] <= wr_ptr[g] + 1'b1;
                if (dec[g]) rd_ptr[g] <= rd_ptr[g] + 1'b1;
                cnt[g] <= cnt[g] + CNT_W'(inc[g]) - CNT_W'(dec[g]);
            end
        end

        assert property (@(posedge CLK) disable iff (RST) cnt[g] <= CNT_W'(DEPTH));
        assert property (@(posedge CLK) disable iff (RST)
            !(inc[g] && !dec[g] && full[g]) && !(dec[g] && !inc[g] && empty[g]));
    end

    always_ff @(posedge CLK) begin
        if (!RST && wr_acc) mem[wr_ch][wr_ptr[wr_ch]] <= wr_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= mem[rd_ch][rd_ptr[rd_ch]];
        end
    end

    // A new error in the clearing cycle survives the clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_full_err  <= '0;
            rd_empty_err <= '0;
        end else begin
            wr_full_err  <= (wr_full_err & ~{NUM_CH{err_clr}}) | wr_err;
            rd_empty_err <= (rd_empty_err & ~{NUM_CH{err_clr}}) | rd_err;
        end
    end

    assert property (@(posedge CLK) disable iff (RST) rd_valid |-> $past(rd_acc));
endmodule

// File: tb/tb_fifo_mem_mc.sv
// tb_fifo_mem_mc: directed checks of fifo_mem_mc with DEPTH=16, four 32-bit channels.
module tb_fifo_mem_mc;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 16;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int CH_W   = 2;

    logic CLK = 1'b0, RST = 1'b1;
    logic wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
    logic [CH_W-1:0] wr_ch = '0, rd_ch = '0;
    logic [WIDTH-1:0] wr_data = '0, rd_data;
    logic rd_valid;
    logic [NUM_CH-1:0] full, empty, almost_full, almost_empty, wr_full_err, rd_empty_err;
    logic [NUM_CH*CNT_W-1:0] count;
    int checks = 0, errors = 0;

    fifo_mem_mc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
        .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .wr_full_err(wr_full_err), .rd_empty_err(rd_empty_err), .err_clr(err_clr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] cn(input int ch);
        return count[ch*CNT_W +: CNT_W];
    endfunction

    // Apply one cycle of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic we, input int wc, input logic [WIDTH-1:0] wd,
                         input logic re, input int rc, input logic clr);
        wr_en = we; wr_ch = CH_W'(wc); wr_data = wd;
        rd_en = re; rd_ch = CH_W'(rc); err_clr = clr;
        @(posedge CLK); #1;
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        int wn, rn, mc, i;
        logic dw, dr;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 4'hF);
        chk("rst_aempty", almost_empty, 4'hF);
        chk("rst_full", full, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_rdata", rd_data, 0);
        chk("rst_errs", {wr_full_err, rd_empty_err}, 0);
        RST = 1'b0;

        for (int k = 0; k < 4; k++) drive(1, 1, 32'hA0 + k, 0, 0, 0);
        chk("ch1_cnt4", cn(1), 4);
        chk("ch1_empty", empty, 4'hD);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1, 1, 0);
            chk("ch1_valid", rd_valid, 1);
            chk("ch1_data", rd_data, 32'hA0 + k);
        end
        chk("ch1_cnt0", cn(1), 0);
        chk("ch1_empty_again", empty[1], 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("idle_valid", rd_valid, 0);
        chk("idle_hold", rd_data, 32'hA3);

        for (int k = 0; k < DEPTH; k++) drive(1, 0, 32'h100 + k, 0, 0, 0);
        chk("ch0_full", full, 4'h1);
        chk("ch0_afull", almost_full[0], 1);
        chk("ch0_cnt", cn(0), DEPTH);
        drive(1, 0, 32'hDEAD, 0, 0, 0);
        chk("ch0_ovf_err", wr_full_err, 4'h1);
        chk("ch0_ovf_cnt", cn(0), DEPTH);
        chk("ch2_untouched", {cn(2), empty[2]}, {5'd0, 1'b1});
        drive(0, 0, 0, 0, 0, 1);
        chk("err_clr", wr_full_err, 0);
        drive(1, 0, 32'hBEEF, 0, 0, 1);
        chk("err_clr_new_wins", wr_full_err, 4'h1);
        drive(0, 0, 0, 0, 0, 1);
        chk("err_clr2", wr_full_err, 0);
        for (int k = 0; k < DEPTH; k++) begin
            drive(0, 0, 0, 1, 0, 0);
            chk("ch0_drain", rd_data, 32'h100 + k);
        end
        chk("ch0_drained", cn(0), 0);

        for (int k = 0; k < DEPTH; k++) drive(1, 2, 32'h200 + k, 0, 0, 0);
        chk("ch2_full", full[2], 1);
        drive(1, 2, 32'h2FF, 1, 2, 0);
        chk("ch2_full_rw_data", rd_data, 32'h200);
        chk("ch2_full_rw_valid", rd_valid, 1);
        chk("ch2_full_rw_cnt", cn(2), DEPTH);
        chk("ch2_full_rw_errs", {wr_full_err, rd_empty_err}, 0);
        for (int k = 1; k <= DEPTH; k++) begin
            drive(0, 0, 0, 1, 2, 0);
            chk("ch2_drain", rd_data, (k == DEPTH) ? 32'h2FF : 32'h200 + k);
        end
        chk("ch2_empty", empty[2], 1);
        drive(1, 2, 32'h2EE, 1, 2, 0);
        chk("ch2_empty_rw_err", rd_empty_err, 4'h4);
        chk("ch2_empty_rw_cnt", cn(2), 1);
        chk("ch2_empty_rw_valid", rd_valid, 0);
        chk("ch2_empty_rw_hold", rd_data, 32'h2FF);
        drive(0, 0, 0, 1, 2, 1);
        chk("ch2_late_data", rd_data, 32'h2EE);
        chk("ch2_err_clr", rd_empty_err, 0);

        // Write slots 0,2,4,6,7 of every 8 cycles, read slots 1,3,5: net +2 per group.
        wn = 0; rn = 0; mc = 0; i = 0;
        while ((wn < 3 * DEPTH || mc > 0) && i < 400) begin
            dw = (wn < 3 * DEPTH) && (mc < DEPTH) && ((i % 8) inside {0, 2, 4, 6, 7} || mc == 0);
            dr = !dw && mc > 0;
            drive(dw, 3, 32'h300 + wn, dr, 3, 0);
            if (dr) begin
                chk("wrap_data", rd_data, 32'h300 + rn);
                rn++; mc--;
            end
            if (dw) begin
                wn++; mc++;
            end
            chk("wrap_cnt", cn(3), mc);
            chk("wrap_afull", almost_full[3], mc >= DEPTH - 2);
            chk("wrap_aempty", almost_empty[3], mc <= 2);
            chk("wrap_full", full[3], mc == DEPTH);
            i++;
        end
        chk("wrap_done", {wn[7:0], rn[7:0]}, {8'd48, 8'd48});
        chk("wrap_errs", {wr_full_err, rd_empty_err}, 0);

        for (int k = 0; k < 10; k++) drive(1, 1, 32'h110 + k, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 32'h400 + k, 1, 1, 0);
            chk("cross_data", rd_data, 32'h110 + k);
        end
        chk("cross_cnt0", cn(0), 10);
        chk("cross_cnt1", cn(1), 0);
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 1, 0, 0);
            chk("cross_ch0_data", rd_data, 32'h400 + k);
        end

        drive(0, 0, 0, 1, 1, 0);
        chk("pre_rst_err", rd_empty_err, 4'h2);
        drive(1, 0, 32'h5A, 0, 0, 0);
        drive(1, 0, 32'h5B, 0, 0, 0);
        RST = 1'b1;
        drive(1, 0, 32'h5C, 1, 0, 1);
        RST = 1'b0;
        chk("midrst_count", count, 0);
        chk("midrst_valid", rd_valid, 0);
        chk("midrst_errs", {wr_full_err, rd_empty_err}, 0);
        chk("midrst_empty", empty, 4'hF);
        chk("midrst_rdata", rd_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_mem_mc.md
Name: fifo_mem_mc

Overview:
- Parametrised multi-channel successor to the single-queue FIFO memory.
- Holds NUM_CH independent circular queues of DEPTH x WIDTH words, with one write port and one read port, each steered by a channel index.
- Adds per-channel occupancy counts, almost-full/almost-empty flags, sticky error flags with explicit clear, and correct pointer wrap.
- Sits between the FIFO control interface and downstream consumers that arbitrate between several streams.

Parameters:
- WIDTH, 32, data word width in bits
- DEPTH, 32, words per channel; power of two, >= 2
- NUM_CH, 4, number of independent channels; >= 1
- AFULL_LVL, DEPTH-2, almost_full asserts when count >= AFULL_LVL
- AEMPTY_LVL, 2, almost_empty asserts when count <= AEMPTY_LVL
- Derived: PTR_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1); CH_W = max(1, $clog2(NUM_CH))

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_ch  in  CH_W  target channel of the write
- wr_data  in  WIDTH  write data
- rd_en  in  1  read request
- rd_ch  in  CH_W  source channel of the read
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  one-cycle pulse; rd_data holds a dequeued word
- full  out  NUM_CH  per channel, count == DEPTH
- empty  out  NUM_CH  per channel, count == 0
- almost_full  out  NUM_CH  per channel, count >= AFULL_LVL
- almost_empty  out  NUM_CH  per channel, count <= AEMPTY_LVL
- count  out  NUM_CH*CNT_W  packed per-channel occupancy; channel i at [i*CNT_W +: CNT_W]
- wr_full_err  out  NUM_CH  sticky; write rejected on that channel
- rd_empty_err  out  NUM_CH  sticky; read rejected on that channel
- err_clr  in  1  clears all sticky error bits

Behaviour:
- Reset (RST high at a CLK edge):
  - All counts and pointers go to 0.
  - rd_data = 0, rd_valid = 0, all error bits = 0.
  - empty = all ones, full = 0, almost_empty = all ones, almost_full = 0.
  - Storage contents are not cleared.
  - Reset overrides any concurrent wr_en, rd_en or err_clr.
- Channel index >= NUM_CH: the request is ignored. No state change, no error, no rd_valid.
- Accepted write (wr_en, valid channel, not full):
  - mem[ch][wr_ptr] <= wr_data.
  - wr_ptr advances; wrap from DEPTH-1 to 0 by natural PTR_W overflow.
- Accepted read (rd_en, valid channel, not empty):
  - rd_data <= mem[ch][rd_ptr]; rd_valid = 1 on the next cycle.
  - rd_ptr advances with the same wrap rule.
  - Latency is 1 cycle from the rd_en edge.
- Rejected write: full channel, with no same-channel read accepted in the same cycle.
  - No storage or count change.
  - wr_full_err[ch] <= 1.
- Rejected read: empty channel.
  - No change to rd_data or count.
  - rd_valid = 0; rd_empty_err[ch] <= 1.
  - A same-cycle write to that channel is still accepted. There is no bypass.
- Simultaneous read and write, same channel:
  - Full: both accepted, count unchanged, no error.
  - Empty: write accepted, read rejected with error, count becomes 1.
  - Otherwise: both accepted, count unchanged.
  - Read returns the old head. It never returns the word being written.
- Simultaneous read and write, different channels: fully independent. Each channel's count changes by +1 or -1.
- count[ch] is always in 0..DEPTH. Status flags are combinational decodes of the registered counts.
- rd_data holds its last value when no read is accepted. rd_valid is never asserted for two reads unless reads are accepted on consecutive cycles.
- Error bits:
  - err_clr clears all bits.
  - A new error in the same cycle as err_clr wins; that bit remains 1.
  - Errors never self-clear.
- Assertions:
  - No count over- or underflow.
  - rd_valid implies the prior cycle had an accepted read.

Test Plan:
- Reset, then write 0xA0..0xA3 to ch1 and read ch1 four times -> rd_data = 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles with rd_valid high; count[1] goes 4->0; empty[1] = 1.
- Fill ch0 with DEPTH words, then one extra write -> full[0] = 1, wr_full_err[0] = 1, count[0] = DEPTH; after err_clr -> wr_full_err[0] = 0; ch2 is unaffected.
- Wrap test: write/read 3*DEPTH words on ch3, interleaving 5 writes and 3 reads -> data order preserved across pointer wrap; almost_full[3] asserts exactly at count = DEPTH-2.
- With ch2 full, read and write ch2 in the same cycle -> no error, count[2] stays DEPTH, rd_data = oldest word. With ch2 empty, the same stimulus -> rd_empty_err[2] = 1, count[2] = 1, rd_valid = 0.
- Write ch0 while reading ch1 for 10 cycles -> count[0] +10, count[1] -10; no cross-channel corruption.
- Assert RST mid-burst with wr_en and rd_en high -> next cycle all counts = 0, rd_valid = 0, all error bits = 0, empty = all ones.
